// File: rtl/move_ctrl_pkg.sv
// Shared types for the move-check initiator: move codes, FSM states, active-block record.
package move_ctrl_pkg;

  localparam int unsigned COL_W    = 4;
  localparam int unsigned ROW_W    = 5;
  localparam int unsigned COLORS_W = 3;

  typedef enum logic [2:0] {
    MOVE_LEFT   = 3'd0,
    MOVE_RIGHT  = 3'd1,
    MOVE_DOWN   = 3'd2,
    MOVE_ROTATE = 3'd3,
    MOVE_APPEAR = 3'd4
  } move_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StWait,
    StApply
  } state_e;

  typedef struct packed {
    logic [63:0]         data;
    logic [COLORS_W-1:0] color;
    logic [1:0]          rotation;
    logic [COL_W:0]      x;
    logic [ROW_W:0]      y;
  } block_t;

  // Player may only issue the four in-field moves; APPEAR and 5..7 are not user codes.
  function automatic logic is_user_move(logic [2:0] m);
    return m <= 3'(MOVE_ROTATE);
  endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Run/done handshake between the move initiator and the move checker.
interface move_ctrl_if;
  import move_ctrl_pkg::*;

  logic       run;
  move_t      move;
  logic       done;
  logic       can;
  logic [1:0] dx;
  logic [1:0] dy;

  modport master (output run, move, input done, can, dx, dy);
  modport slave  (input run, move, output done, can, dx, dy);
endinterface

// File: rtl/move_ctrl_arb.sv
// Fixed-priority request select (appear > tick > user) with a one-deep pending gravity tick.
module move_ctrl_arb
  import move_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       idle_i,
  input  logic       active_i,
  input  logic       game_over_i,
  input  logic       restart_i,
  input  logic       appear_req_i,
  input  logic       drop_tick_i,
  input  logic       user_valid_i,
  input  logic [2:0] user_move_i,
  output logic       sel_valid_o,
  output move_t      sel_move_o,
  output logic       user_ready_o
);

  logic pend_q, pend_d;
  logic active_prev_q;
  logic appear_ok, tick_ok, user_ok, take_tick;

  assign appear_ok    = appear_req_i & ~active_i & ~game_over_i;
  assign tick_ok      = active_i & (pend_q | drop_tick_i);
  assign user_ready_o = idle_i & active_i & ~pend_q & ~drop_tick_i;
  assign user_ok      = user_ready_o & user_valid_i & is_user_move(user_move_i);

  always_comb begin
    sel_valid_o = 1'b0;
    sel_move_o  = MOVE_LEFT;
    take_tick   = 1'b0;
    if (idle_i) begin
      if (appear_ok) begin
        sel_valid_o = 1'b1;
        sel_move_o  = MOVE_APPEAR;
      end else if (tick_ok) begin
        sel_valid_o = 1'b1;
        sel_move_o  = MOVE_DOWN;
        take_tick   = 1'b1;
      end else if (user_ok) begin
        sel_valid_o = 1'b1;
        sel_move_o  = move_t'(user_move_i);
      end
    end
  end

  // A tick taken in the same cycle as a fresh one absorbs both; extra ticks are dropped.
  always_comb begin
    pend_d = pend_q;
    if (drop_tick_i) pend_d = 1'b1;
    if (take_tick) pend_d = 1'b0;
    if ((active_prev_q & ~active_i) | (idle_i & restart_i)) pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q        <= 1'b0;
      active_prev_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      active_prev_q <= active_i;
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Move-check initiator: issues one check per arbitrated request and commits the verdict
// into the active block state.
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter int SPAWN_X     = 3,
  parameter int SPAWN_Y     = 0,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                appear_req_i,
  input  logic [63:0]         new_data_i,
  input  logic [COLORS_W-1:0] new_color_i,
  output logic                appear_ack_o,
  input  logic                drop_tick_i,
  input  logic                user_valid_i,
  input  logic [2:0]          user_move_i,
  output logic                user_ready_o,
  move_ctrl_if.master         chk_if,
  output logic [63:0]         block_data_o,
  output logic [COLORS_W-1:0] block_color_o,
  output logic [1:0]          block_rot_o,
  output logic [COL_W:0]      block_x_o,
  output logic [ROW_W:0]      block_y_o,
  output logic                active_o,
  output logic                landed_o,
  output logic                reject_o,
  output logic                game_over_o,
  input  logic                restart_i,
  output logic                err_timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

  state_e          state_q;
  move_t           move_q;
  block_t          blk_q;
  logic [CntW-1:0] cnt_q;
  logic            ack_q, run_q, active_q, landed_q, reject_q, game_over_q, err_q;
  logic            sel_valid;
  move_t           sel_move;

  move_ctrl_arb u_arb (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .idle_i       (state_q == StIdle),
    .active_i     (active_q),
    .game_over_i  (game_over_q),
    .restart_i    (restart_i),
    .appear_req_i (appear_req_i),
    .drop_tick_i  (drop_tick_i),
    .user_valid_i (user_valid_i),
    .user_move_i  (user_move_i),
    .sel_valid_o  (sel_valid),
    .sel_move_o   (sel_move),
    .user_ready_o (user_ready_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      move_q      <= MOVE_LEFT;
      blk_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      run_q       <= 1'b0;
      active_q    <= 1'b0;
      landed_q    <= 1'b0;
      reject_q    <= 1'b0;
      game_over_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
      landed_q <= 1'b0;
      reject_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (restart_i) game_over_q <= 1'b0;
          if (sel_valid) begin
            move_q  <= sel_move;
            ack_q   <= (sel_move == MOVE_APPEAR);
            run_q   <= (sel_move != MOVE_APPEAR);
            state_q <= (sel_move == MOVE_APPEAR) ? StLoad : StRun;
          end
        end
        StLoad: begin
          blk_q.data     <= new_data_i;
          blk_q.color    <= new_color_i;
          blk_q.rotation <= 2'd0;
          blk_q.x        <= (COL_W+1)'(SPAWN_X);
          blk_q.y        <= (ROW_W+1)'(SPAWN_Y);
          run_q          <= 1'b1;
          state_q        <= StRun;
        end
        StRun: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Verdict is committed here so the new state is visible during APPLY.
          if (chk_if.done) begin
            state_q <= StApply;
            if (chk_if.can) begin
              blk_q.x <= blk_q.x + {{(COL_W-1){chk_if.dx[1]}}, chk_if.dx};
              blk_q.y <= blk_q.y + {{(ROW_W-1){chk_if.dy[1]}}, chk_if.dy};
              if (move_q == MOVE_ROTATE) blk_q.rotation <= blk_q.rotation + 2'd1;
              if (move_q == MOVE_APPEAR) active_q <= 1'b1;
            end else begin
              unique case (move_q)
                MOVE_DOWN: begin
                  landed_q <= 1'b1;
                  active_q <= 1'b0;
                end
                MOVE_APPEAR: begin
                  game_over_q <= 1'b1;
                  active_q    <= 1'b0;
                end
                default: reject_q <= 1'b1;
              endcase
            end
          end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StApply: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign chk_if.run    = run_q;
  assign chk_if.move   = move_q;
  assign appear_ack_o  = ack_q;
  assign block_data_o  = blk_q.data;
  assign block_color_o = blk_q.color;
  assign block_rot_o   = blk_q.rotation;
  assign block_x_o     = blk_q.x;
  assign block_y_o     = blk_q.y;
  assign active_o      = active_q;
  assign landed_o      = landed_q;
  assign reject_o      = reject_q;
  assign game_over_o   = game_over_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl; the checker side of the handshake is played by the bench.
module tb_move_ctrl;
  import move_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        appear_req_i, drop_tick_i, user_valid_i, restart_i;
  logic [63:0] new_data_i;
  logic [2:0]  new_color_i, user_move_i;
  logic        appear_ack_o, user_ready_o, active_o, landed_o, reject_o, game_over_o;
  logic        err_timeout_o;
  logic [63:0] block_data_o;
  logic [2:0]  block_color_o;
  logic [1:0]  block_rot_o;
  logic [4:0]  block_x_o;
  logic [5:0]  block_y_o;

  int errors = 0;
  int checks = 0;

  move_ctrl_if chk ();

  move_ctrl u_dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .appear_req_i  (appear_req_i),
    .new_data_i    (new_data_i),
    .new_color_i   (new_color_i),
    .appear_ack_o  (appear_ack_o),
    .drop_tick_i   (drop_tick_i),
    .user_valid_i  (user_valid_i),
    .user_move_i   (user_move_i),
    .user_ready_o  (user_ready_o),
    .chk_if        (chk),
    .block_data_o  (block_data_o),
    .block_color_o (block_color_o),
    .block_rot_o   (block_rot_o),
    .block_x_o     (block_x_o),
    .block_y_o     (block_y_o),
    .active_o      (active_o),
    .landed_o      (landed_o),
    .reject_o      (reject_o),
    .game_over_o   (game_over_o),
    .restart_i     (restart_i),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (chk.run === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  // Returns at the APPLY-cycle negedge.
  task automatic respond(input logic can, input logic [1:0] dx, input logic [1:0] dy);
    @(negedge clk_i);
    chk.done = 1'b1; chk.can = can; chk.dx = dx; chk.dy = dy;
    @(negedge clk_i);
    chk.done = 1'b0;
  endtask

  task automatic user_req(input logic [2:0] m);
    @(negedge clk_i);
    user_valid_i = 1'b1; user_move_i = m;
    @(negedge clk_i);
    user_valid_i = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] m, input logic can, input logic [1:0] dx,
                         input logic [1:0] dy, output bit ok);
    user_req(m);
    wait_run(ok);
    if (ok) respond(can, dx, dy);
  endtask

  task automatic appear_start(input logic [63:0] d, input logic [2:0] c,
                              output logic ack, output bit ran);
    @(negedge clk_i);
    appear_req_i = 1'b1; new_data_i = d; new_color_i = c;
    @(negedge clk_i);
    ack = appear_ack_o;
    appear_req_i = 1'b0;
    wait_run(ran);
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if ({active_o, appear_ack_o, chk.run, game_over_o, err_timeout_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
        {active_o, appear_ack_o, chk.run, game_over_o, err_timeout_o}); end
    checks++; if (block_data_o !== 64'h0 || block_x_o !== 5'd0) begin
      errors++; $display("FAIL reset_block: got %h/%0d want 0/0", block_data_o, block_x_o); end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++; if (user_ready_o !== 1'b0 || chk.run !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ready=%b run=%b want 0 0", user_ready_o, chk.run); end
  endtask

  task automatic test_appear;
    logic ack; bit ran;
    appear_start(64'hDEAD_BEEF_0123_4567, 3'd5, ack, ran);
    checks++; if (ack !== 1'b1) begin
      errors++; $display("FAIL appear_ack: got %b want 1", ack); end
    checks++; if (!ran) begin
      errors++; $display("FAIL appear_run: got no run want run"); end
    checks++; if (chk.move !== 3'd4) begin
      errors++; $display("FAIL appear_move: got %0d want 4", chk.move); end
    respond(1'b1, 2'b00, 2'b00);
    checks++; if (active_o !== 1'b1 || game_over_o !== 1'b0) begin
      errors++; $display("FAIL appear_active: got act=%b go=%b want 1 0", active_o, game_over_o); end
    checks++; if (block_x_o !== 5'd3 || block_y_o !== 6'd0 || block_rot_o !== 2'd0) begin
      errors++; $display("FAIL appear_pos: got x=%0d y=%0d r=%0d want 3 0 0",
        block_x_o, block_y_o, block_rot_o); end
    checks++; if (block_data_o !== 64'hDEAD_BEEF_0123_4567 || block_color_o !== 3'd5) begin
      errors++; $display("FAIL appear_data: got %h/%0d want deadbeef01234567/5",
        block_data_o, block_color_o); end
    checks++; if (appear_ack_o !== 1'b0) begin
      errors++; $display("FAIL appear_ack_pulse: got %b want 0", appear_ack_o); end
  endtask

  task automatic test_reject_left;
    bit ok;
    for (int i = 0; i < 3; i++) do_move(3'd0, 1'b1, 2'b11, 2'b00, ok);
    checks++; if (block_x_o !== 5'd0) begin
      errors++; $display("FAIL left_x: got %0d want 0", block_x_o); end
    do_move(3'd0, 1'b0, 2'b00, 2'b00, ok);
    checks++; if (!ok || chk.move !== 3'd0) begin
      errors++; $display("FAIL left_move: got ok=%b move=%0d want 1 0", ok, chk.move); end
    checks++; if (reject_o !== 1'b1 || landed_o !== 1'b0 || active_o !== 1'b1) begin
      errors++; $display("FAIL left_reject: got rej=%b land=%b act=%b want 1 0 1",
        reject_o, landed_o, active_o); end
    checks++; if (block_x_o !== 5'd0) begin
      errors++; $display("FAIL left_hold: got %0d want 0", block_x_o); end
    @(negedge clk_i);
    checks++; if (reject_o !== 1'b0) begin
      errors++; $display("FAIL left_pulse: got %b want 0", reject_o); end
  endtask

  task automatic test_right_rotate;
    bit ok;
    for (int i = 0; i < 3; i++) do_move(3'd1, 1'b1, 2'b01, 2'b00, ok);
    for (int i = 0; i < 3; i++) do_move(3'd3, 1'b1, 2'b00, 2'b00, ok);
    checks++; if (block_x_o !== 5'd3 || block_rot_o !== 2'd3) begin
      errors++; $display("FAIL rot_setup: got x=%0d r=%0d want 3 3", block_x_o, block_rot_o); end
    do_move(3'd1, 1'b1, 2'b01, 2'b00, ok);
    checks++; if (block_x_o !== 5'd4) begin
      errors++; $display("FAIL right_x: got %0d want 4", block_x_o); end
    do_move(3'd3, 1'b1, 2'b00, 2'b00, ok);
    checks++; if (block_rot_o !== 2'd0 || block_x_o !== 5'd4) begin
      errors++; $display("FAIL rot_wrap: got r=%0d x=%0d want 0 4", block_rot_o, block_x_o); end
  endtask

  task automatic test_pending_tick;
    bit ok;
    user_req(3'd0);
    wait_run(ok);
    drop_tick_i = 1'b1;
    @(negedge clk_i);
    drop_tick_i = 1'b0;
    chk.done = 1'b1; chk.can = 1'b1; chk.dx = 2'b11; chk.dy = 2'b00;
    @(negedge clk_i);
    chk.done = 1'b0;
    checks++; if (block_x_o !== 5'd3) begin
      errors++; $display("FAIL pend_left_x: got %0d want 3", block_x_o); end
    @(negedge clk_i);
    checks++; if (user_ready_o !== 1'b0) begin
      errors++; $display("FAIL pend_ready: got %b want 0", user_ready_o); end
    wait_run(ok);
    checks++; if (!ok || chk.move !== 3'd2) begin
      errors++; $display("FAIL pend_run: got ok=%b move=%0d want 1 2", ok, chk.move); end
    respond(1'b1, 2'b00, 2'b01);
    checks++; if (block_y_o !== 6'd1 || block_x_o !== 5'd3) begin
      errors++; $display("FAIL pend_down: got y=%0d x=%0d want 1 3", block_y_o, block_x_o); end
    @(negedge clk_i);
    checks++; if (user_ready_o !== 1'b1 || chk.run !== 1'b0) begin
      errors++; $display("FAIL pend_clear: got ready=%b run=%b want 1 0", user_ready_o, chk.run); end
  endtask

  task automatic test_land_game_over;
    bit ok, ran; logic ack, any_ack;
    do_move(3'd2, 1'b0, 2'b00, 2'b00, ok);
    checks++; if (landed_o !== 1'b1 || active_o !== 1'b0 || block_y_o !== 6'd1) begin
      errors++; $display("FAIL land: got land=%b act=%b y=%0d want 1 0 1",
        landed_o, active_o, block_y_o); end
    @(negedge clk_i);
    checks++; if (landed_o !== 1'b0 || user_ready_o !== 1'b0) begin
      errors++; $display("FAIL land_pulse: got land=%b ready=%b want 0 0", landed_o, user_ready_o); end
    appear_start(64'h0000_0000_0000_F000, 3'd2, ack, ran);
    respond(1'b0, 2'b00, 2'b00);
    checks++; if (game_over_o !== 1'b1 || active_o !== 1'b0 || reject_o !== 1'b0) begin
      errors++; $display("FAIL game_over: got go=%b act=%b rej=%b want 1 0 0",
        game_over_o, active_o, reject_o); end
    appear_req_i = 1'b1;
    any_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      any_ack = any_ack | appear_ack_o | chk.run;
    end
    appear_req_i = 1'b0;
    checks++; if (any_ack !== 1'b0 || game_over_o !== 1'b1) begin
      errors++; $display("FAIL go_block: got ack_or_run=%b go=%b want 0 1", any_ack, game_over_o); end
    restart_i = 1'b1;
    @(negedge clk_i);
    restart_i = 1'b0;
    checks++; if (game_over_o !== 1'b0 || active_o !== 1'b0) begin
      errors++; $display("FAIL restart: got go=%b act=%b want 0 0", game_over_o, active_o); end
  endtask

  task automatic test_timeout;
    logic ack; bit ran;
    appear_start(64'h1234_0000_0000_0000, 3'd1, ack, ran);
    checks++; if (ack !== 1'b1 || !ran) begin
      errors++; $display("FAIL to_start: got ack=%b run=%b want 1 1", ack, ran); end
    repeat (32) @(negedge clk_i);
    checks++; if (err_timeout_o !== 1'b0) begin
      errors++; $display("FAIL to_early: got %b want 0", err_timeout_o); end
    @(negedge clk_i);
    checks++; if (err_timeout_o !== 1'b1 || active_o !== 1'b0) begin
      errors++; $display("FAIL to_set: got err=%b act=%b want 1 0", err_timeout_o, active_o); end
    chk.done = 1'b1; chk.can = 1'b1;
    @(negedge clk_i);
    chk.done = 1'b0;
    @(negedge clk_i);
    checks++; if (active_o !== 1'b0 || err_timeout_o !== 1'b1) begin
      errors++; $display("FAIL to_late_done: got act=%b err=%b want 0 1", active_o, err_timeout_o); end
    appear_start(64'h0000_0000_0000_00FF, 3'd6, ack, ran);
    checks++; if (ack !== 1'b1 || !ran) begin
      errors++; $display("FAIL to_idle: got ack=%b run=%b want 1 1", ack, ran); end
    respond(1'b1, 2'b00, 2'b00);
    checks++; if (active_o !== 1'b1 || block_color_o !== 3'd6) begin
      errors++; $display("FAIL to_recover: got act=%b col=%0d want 1 6", active_o, block_color_o); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    user_req(3'd2);
    wait_run(ok);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checks++; if ({active_o, chk.run, err_timeout_o, user_ready_o, landed_o} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 00000",
        {active_o, chk.run, err_timeout_o, user_ready_o, landed_o}); end
    checks++; if (block_data_o !== 64'h0 || block_x_o !== 5'd0 || block_color_o !== 3'd0) begin
      errors++; $display("FAIL rst_mid_block: got %h x=%0d c=%0d want 0", block_data_o,
        block_x_o, block_color_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk.done = 1'b1; chk.can = 1'b0;
    @(negedge clk_i);
    chk.done = 1'b0;
    @(negedge clk_i);
    checks++; if ({landed_o, reject_o, game_over_o, active_o} !== 4'b0) begin
      errors++; $display("FAIL rst_late_done: got %b want 0000",
        {landed_o, reject_o, game_over_o, active_o}); end
  endtask

  initial begin
    appear_req_i = 1'b0; drop_tick_i = 1'b0; user_valid_i = 1'b0; restart_i = 1'b0;
    new_data_i = '0; new_color_i = '0; user_move_i = '0;
    chk.done = 1'b0; chk.can = 1'b0; chk.dx = 2'b00; chk.dy = 2'b00;
    test_reset();
    test_appear();
    test_reject_left();
    test_right_rotate();
    test_pending_tick();
    test_land_game_over();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
